// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch buffer.
// Used by the fetch FIFO and by the fetch control top level.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO of {pc, instr} pairs between fetch and decode.
// A flush empties the queue; a pop in the same cycle is consumed first.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // The head leaving on a flush cycle has already been handed to decode,
  // so clearing everything afterwards yields an empty queue either way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_ifetch_buffer.sv
// Instruction-fetch stage: owns the fetch PC, buffers {pc, instr} pairs
// for decode, and handles redirects, halt-on-zero and misaligned faults.
module mips_ifetch_buffer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = mips_fetch_pkg::RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = mips_fetch_pkg::HALT_ADDR,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        active,
  output logic        fault,
  output logic [31:0] delivered_count
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  fetch_pc;
  logic [31:0]  fetch_pc_next;
  logic         push;
  logic         pop;
  logic         flush;
  logic         full;
  logic         empty;
  fetch_entry_t head;
  fetch_entry_t wr_entry;

  assign instr_address  = fetch_pc;
  assign out_valid      = !empty;
  assign pop            = !empty && out_ready;
  assign out_pc         = head.pc;
  assign out_instr      = head.instr;
  assign wr_entry.pc    = fetch_pc;
  assign wr_entry.instr = instr_readdata;
  assign active         = (state == RUN) || !empty;
  assign fault          = (state == FAULT);

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= RUN;
      fetch_pc        <= RESET_VECTOR;
      delivered_count <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (pop) begin
        delivered_count <= delivered_count + 32'd1;
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full queue still accepts
  // a push while decode is draining it.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    flush         = 1'b0;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_target == HALT_ADDR) begin
            state_next = HALT;
          end else if (redirect_target[1:0] != 2'b00) begin
            state_next = FAULT;
          end else begin
            fetch_pc_next = redirect_target;
          end
        end else if (!full || pop) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + 32'd4;
        end
      end
      default: begin
        state_next = state;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_ifetch_buffer.sv
// Bench for mips_ifetch_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mips_ifetch_buffer;

  localparam logic [31:0] RV    = 32'hBFC0_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        active;
  logic        fault;
  logic [31:0] delivered_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_ifetch_buffer dut (
    .clk             (clk),
    .reset           (reset),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .active          (active),
    .fault           (fault),
    .delivered_count (delivered_count)
  );

  // Instruction RAM contents: lw r2,0(r0) at the reset vector, a pattern elsewhere.
  function automatic logic [31:0] ram(input logic [31:0] a);
    if (a == RV) return 32'h8C02_0000;
    return (a ^ 32'hA5A5_0000) + 32'd1;
  endfunction

  assign instr_readdata = ram(instr_address);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: a list of pending fetches, a fetch address and a mode.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  int          m_mode;   // 0 fetching, 1 halted, 2 faulted
  logic [31:0] m_del;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_pc   = RV;
      m_mode = 0;
      m_del  = 32'd0;
    end else begin
      if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
        m_del = m_del + 32'd1;
      end
      if (redirect_valid && m_mode == 0) begin
        q.delete();
        if (redirect_target == 32'd0) m_mode = 1;
        else if (redirect_target % 4 != 0) m_mode = 2;
        else m_pc = redirect_target;
      end else if (m_mode == 0 && q.size() < DEPTH) begin
        q.push_back('{pc: m_pc, instr: ram(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("m_addr", instr_address, m_pc);
      chk("m_active", 32'(active), 32'((m_mode == 0) || (q.size() > 0)));
      chk("m_fault", 32'(fault), 32'(m_mode == 2));
      chk("m_count", delivered_count, m_del);
      if (q.size() > 0) begin
        chk("m_pc", out_pc, q[0].pc);
        chk("m_instr", out_instr, q[0].instr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd1);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_count"}, delivered_count, 32'd0);
    chk({tag, "_addr"}, instr_address, RV);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset_vals("rst");
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  logic [31:0] addr_hold;
  bit          found;

  initial begin
    reset           = 1'b0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    #1;

    // Streaming from reset with decode always ready.
    out_ready = 1'b1;
    do_reset();
    step();
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_pc", out_pc, 32'hBFC0_0000);
    chk("first_instr", out_instr, 32'h8C02_0000);
    chk("first_addr", instr_address, 32'hBFC0_0004);
    step(); step(); step();
    chk("stream_pc", out_pc, 32'hBFC0_000C);
    chk("stream_count", delivered_count, 32'd3);

    // Decode stalls: buffer fills to two entries, fetch address freezes.
    out_ready = 1'b0;
    do_reset();
    repeat (5) step();
    chk("stall_addr", instr_address, 32'hBFC0_0008);
    chk("stall_pc", out_pc, 32'hBFC0_0000);
    out_ready = 1'b1;
    step();
    chk("drain1_pc", out_pc, 32'hBFC0_0004);
    chk("drain1_count", delivered_count, 32'd1);
    step();
    chk("drain2_pc", out_pc, 32'hBFC0_0008);

    // Branch taken while the delay slot at BFC00010 is popped.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (out_valid && out_pc == 32'hBFC0_0010) found = 1'b1;
      else step();
    end
    chk("reach_pc10", 32'(found), 32'd1);
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0040;
    step();
    redirect_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_addr", instr_address, 32'hBFC0_0040);
    step();
    chk("target_pc", out_pc, 32'hBFC0_0040);
    step();

    // jr r0: halt while popping the delay slot; later redirects ignored.
    addr_hold       = instr_address;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0000;
    step();
    redirect_valid = 1'b0;
    chk("halt_valid", 32'(out_valid), 32'd0);
    chk("halt_active", 32'(active), 32'd0);
    chk("halt_addr", instr_address, addr_hold);
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0100;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    chk("halt_ignore_addr", instr_address, addr_hold);
    chk("halt_ignore_active", 32'(active), 32'd0);

    // Misaligned redirect: sticky fault, fetch stops.
    do_reset();
    repeat (3) step();
    addr_hold       = instr_address;
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0042;
    step();
    redirect_target = 32'hBFC0_0100;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    chk("fault_flag", 32'(fault), 32'd1);
    chk("fault_addr", instr_address, addr_hold);
    chk("fault_active", 32'(active), 32'd0);

    // Reset lands while full and a redirect is pending.
    do_reset();
    repeat (3) step();
    out_ready = 1'b0;
    repeat (3) step();
    chk("pre_rst_count", delivered_count, 32'd2);
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0040;
    #1;
    reset = 1'b1;
    #1;
    reset_vals("async");
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    step();
    chk("restart_pc", out_pc, 32'hBFC0_0000);
    chk("restart_valid", 32'(out_valid), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_ifetch_buffer.md
Name: mips_ifetch_buffer

Overview:
- Instruction-fetch stage sitting directly downstream of the instruction RAM and upstream of decode.
- Owns the fetch PC and drives the combinational instruction RAM address.
- Captures {pc, instruction} pairs into a small FIFO and hands them to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump/jr) with a flush, halt on a jump to address 0, and a sticky fault on misaligned targets.

Parameters:
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset.
- HALT_ADDR, 32'h00000000, redirect target that stops fetching.
- DEPTH, 2, number of FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- instr_address  out  32  byte address to instruction RAM; equals fetch_pc, driven combinationally.
- instr_readdata  in  32  instruction word, valid in the same cycle as instr_address.
- out_valid  out  1  FIFO head holds a valid entry.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at the FIFO head.
- out_pc  out  32  address of out_instr.
- redirect_valid  in  1  single-cycle pulse; replace fetch_pc.
- redirect_target  in  32  new fetch byte address.
- active  out  1  high until halt/fault and FIFO empty.
- fault  out  1  sticky misaligned-redirect flag.
- delivered_count  out  32  number of completed out handshakes.

Behaviour:
- Reset (asynchronous, active-high):
  - fetch_pc=RESET_VECTOR, FIFO empty, state=RUN.
  - out_valid=0, active=1, fault=0, delivered_count=0.
  - Reset asserted mid-operation discards everything immediately.
- States:
  - RUN: fetching.
  - HALT: fetch stopped by a HALT_ADDR redirect.
  - FAULT: fetch stopped by a misaligned redirect.
  - HALT and FAULT are terminal until reset.
- Push:
  - Condition: state==RUN, FIFO not full, no redirect this cycle.
  - Action: write {fetch_pc, instr_readdata}; fetch_pc += 4 (32-bit wrap, no flag).
  - Throughput: one push per cycle maximum.
- Pop:
  - Condition: out_valid && out_ready.
  - Action: head advances; delivered_count += 1 (wraps at 2^32).
- Simultaneous push and pop:
  - Allowed when full; the pop frees a slot the same cycle.
  - Occupancy is unchanged.
- First entry after reset/redirect: out_valid rises one cycle after the RUN cycle that pushes it (registered FIFO, latency 1).
- Redirect (redirect_valid=1), highest priority:
  - A pop in the same cycle is honoured (delay-slot instruction leaves).
  - All other entries are flushed; no push this cycle.
  - Target==HALT_ADDR → state=HALT; fetch_pc unchanged.
  - Target[1:0]!=0 → state=FAULT, fault=1; fetch_pc unchanged.
  - Otherwise fetch_pc=target; the next cycle pushes the target instruction.
  - Redirect while in HALT or FAULT is ignored.
- Delay slot: decode issues the redirect in the cycle it pops the delay-slot instruction, so the delay slot is never flushed. Issuing the redirect earlier is a decode bug, not handled here.
- active = (state==RUN) || FIFO non-empty. After a flush, active falls the cycle after the redirect.
- Occupancy:
  - Count register is DEPTH+1 values wide.
  - Full blocks push and fetch_pc holds.
  - Empty forces out_valid=0.
  - out_instr/out_pc are don't-care when out_valid=0.

Decomposition:
- Package mips_fetch_pkg:
  - RESET_VECTOR and HALT_ADDR constants.
  - fetch_state_t enum {RUN, HALT, FAULT}.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo:
  - Parameterised DEPTH, element fetch_entry_t.
  - Ports: push/pop/flush, full/empty, head.
  - Async reset.
  - Pop has priority ordering before flush within the same cycle.

Test Plan:
- Reset release, out_ready=1, RAM holds lw r2,0(r0) at 0xBFC00000 → cycle 1 out_valid=1, out_pc=BFC00000, out_instr=8C020000; then consecutive pcs +4 each cycle; delivered_count increments per cycle.
- Hold out_ready=0 for 5 cycles → occupancy caps at 2, instr_address stalls at BFC00008; release → BFC00000, BFC00004, BFC00008 delivered in order, none skipped or duplicated.
- Pop at pc BFC00010 with redirect_valid=1, target BFC00040 → BFC00010 delivered, buffered BFC00014 flushed, next out_pc=BFC00040.
- jr r0 pattern: redirect target 00000000 concurrent with popping the delay-slot addiu → addiu delivered, state HALT, out_valid=0, active=0 next cycle, instr_address frozen.
- Redirect target BFC00042 → fault=1 and stays 1, no further pushes, later redirects ignored.
- Assert reset while full and mid-redirect → outputs return to reset values asynchronously; fetch restarts at BFC00000 after release.
